// File: rtl/msx_slot_responder_if.sv
// Slot-side bus and flash read port of the MSX cartridge responder.
// Strobes and wait_n are active-low, matching the MSX slot pins.
interface msx_slot_responder_if;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        rd;
   logic        wr;
   logic        mreq;
   logic        iorq;
   logic        sltsl;
   logic        m1;
   logic        wait_n;
   logic        busdir;
   logic [19:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic [7:0]  ctrl;

   modport slave (
      input  addr, data_in, rd, wr, mreq, iorq, sltsl, m1, mem_ack, mem_data,
      output data_out, data_oe, wait_n, busdir, mem_addr, mem_req, ctrl
   );

   modport master (
      output addr, data_in, rd, wr, mreq, iorq, sltsl, m1, mem_ack, mem_data,
      input  data_out, data_oe, wait_n, busdir, mem_addr, mem_req, ctrl
   );
endinterface

// File: rtl/msx_slot_responder.sv
// MSX cartridge slot target: ASCII8 mapper, one I/O control register, and
// flash-backed ROM reads that stretch the Z80 cycle with WAIT.
module msx_slot_responder #(
   parameter logic [7:0] IO_PORT  = 8'h5E,
   parameter int         WAIT_MAX = 255,
   parameter int         SYNC_LEN = 2
) (
   input logic                 clk,
   input logic                 reset,
   msx_slot_responder_if.slave bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MRD   = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] DRIVE = 3'd3;
   localparam logic [2:0] IORD  = 3'd4;
   localparam logic [2:0] WHOLD = 3'd5;

   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   // Strobe order in the synchronizer: {rd, wr, mreq, iorq, sltsl, m1}
   logic [5:0]  sync_q [SYNC_LEN];
   logic        rd_s, wr_s, mreq_s, iorq_s, sltsl_s, m1_s;
   logic        rd_prev, wr_prev;

   logic [2:0]  state_q;
   logic [15:0] addr_q;
   logic [6:0]  bank_q [4];
   logic [7:0]  ctrl_q;
   logic [7:0]  data_out_q;
   logic        data_oe_q;
   logic        wait_n_q;
   logic        busdir_q;
   logic [19:0] mem_addr_q;
   logic        mem_req_q;
   logic [7:0]  wait_cnt_q;
   logic        driving_q;

   assign {rd_s, wr_s, mreq_s, iorq_s, sltsl_s, m1_s} = sync_q[SYNC_LEN-1];

   logic rd_fall, wr_fall, mem_sel, io_sel, rom_range;
   logic start_mrd, start_iord, start_wr, mapper_wr;
   logic [6:0] read_bank;

   assign rd_fall    = !rd_s && rd_prev;
   assign wr_fall    = !wr_s && wr_prev;
   assign mem_sel    = !mreq_s && !sltsl_s;
   assign io_sel     = !iorq_s && m1_s && (bus.addr[7:0] == IO_PORT);
   assign rom_range  = (bus.addr[15:14] == 2'b01) || (bus.addr[15:14] == 2'b10);
   // A strobe is rejected when the other one is already low.
   assign start_mrd  = rd_fall && wr_s && mem_sel && rom_range;
   assign start_iord = rd_fall && wr_s && io_sel;
   assign start_wr   = wr_fall && rd_s && (mem_sel || io_sel);
   assign mapper_wr  = start_wr && mem_sel && (bus.addr[15:13] == 3'b011);
   assign read_bank  = bank_q[2'(addr_q[15:13] - 3'd2)];

   assign bus.data_out = data_out_q;
   assign bus.data_oe  = data_oe_q;
   assign bus.wait_n   = wait_n_q;
   assign bus.busdir   = busdir_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_req  = mem_req_q;
   assign bus.ctrl     = ctrl_q;

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values and the result is independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_LEN; i++) sync_q[i] <= '1;
         rd_prev    <= 1'b1;
         wr_prev    <= 1'b1;
         state_q    <= IDLE;
         addr_q     <= '0;
         // NOTE: the bank array is four small registers, not a RAM, so it is
         // reset like ordinary flops.
         for (int i = 0; i < 4; i++) bank_q[i] <= '0;
         ctrl_q     <= '0;
         data_out_q <= 8'hFF;
         data_oe_q  <= 1'b0;
         wait_n_q   <= 1'b1;
         busdir_q   <= 1'b1;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         wait_cnt_q <= '0;
         driving_q  <= 1'b0;
      end else begin
         sync_q[0] <= {bus.rd, bus.wr, bus.mreq, bus.iorq, bus.sltsl, bus.m1};
         for (int i = 1; i < SYNC_LEN; i++) sync_q[i] <= sync_q[i-1];
         rd_prev <= rd_s;
         wr_prev <= wr_s;

         case (state_q)
            IDLE: begin
               if (start_mrd) begin
                  addr_q  <= bus.addr;
                  state_q <= MRD;
               end else if (start_iord) begin
                  addr_q  <= bus.addr;
                  state_q <= IORD;
               end else if (start_wr) begin
                  addr_q  <= bus.addr;
                  state_q <= WHOLD;
                  if (mapper_wr) bank_q[bus.addr[12:11]] <= bus.data_in[6:0];
                  if (io_sel) ctrl_q <= bus.data_in;
               end
            end

            MRD: begin
               // First cycle in MRD issues the request; later cycles wait on it.
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= {read_bank, addr_q[12:0]};
                  wait_n_q   <= 1'b0;
                  wait_cnt_q <= '0;
               end else if (bus.mem_ack) begin
                  data_out_q <= bus.mem_data;
                  data_oe_q  <= 1'b1;
                  wait_n_q   <= 1'b1;
                  mem_req_q  <= 1'b0;
                  state_q    <= DRIVE;
               end else if (wait_cnt_q == WAIT_LIMIT) begin
                  data_out_q <= 8'hFF;
                  data_oe_q  <= 1'b1;
                  wait_n_q   <= 1'b1;
                  driving_q  <= 1'b1;
                  state_q    <= DRAIN;
               end else if (rd_s) begin
                  wait_n_q  <= 1'b1;
                  driving_q <= 1'b0;
                  state_q   <= DRAIN;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end

            DRAIN: begin
               // The flash cycle must complete before the next request; its data is dropped.
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= driving_q ? DRIVE : IDLE;
               end
            end

            DRIVE: begin
               if (rd_s) begin
                  data_oe_q <= 1'b0;
                  busdir_q  <= 1'b1;
                  driving_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end

            IORD: begin
               data_out_q <= ctrl_q;
               data_oe_q  <= 1'b1;
               busdir_q   <= 1'b0;
               state_q    <= DRIVE;
            end

            WHOLD: begin
               if (wr_s) state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msx_slot_responder.sv
// Directed bench for msx_slot_responder: expected addresses and read data are
// queued when a bus cycle is launched and compared when the DUT produces them.
module tb_msx_slot_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   msx_slot_responder_if bus ();

   msx_slot_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check(e.tag, obs, e.value);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic release_bus();
      bus.rd    = 1'b1;
      bus.wr    = 1'b1;
      bus.mreq  = 1'b1;
      bus.iorq  = 1'b1;
      bus.sltsl = 1'b1;
      bus.m1    = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      release_bus();
      bus.mem_ack = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
      bus.addr    = a;
      bus.data_in = d;
      bus.mreq    = 1'b0;
      bus.sltsl   = 1'b0;
      tick(1);
      bus.wr = 1'b0;
      tick(6);
      release_bus();
      tick(4);
   endtask

   task automatic io_write(input logic [7:0] port, input logic [7:0] d);
      bus.addr    = {8'h00, port};
      bus.data_in = d;
      bus.iorq    = 1'b0;
      tick(1);
      bus.wr = 1'b0;
      tick(6);
      release_bus();
      tick(4);
   endtask

   // Launch a ROM read; expected flash address and returned data are queued first.
   task automatic mem_read(input logic [15:0] a, input logic [19:0] exp_addr,
                           input int ack_after, input logic [7:0] d);
      push("mem_addr", {12'h0, exp_addr});
      push("mem_data", {24'h0, d});
      bus.addr  = a;
      bus.mreq  = 1'b0;
      bus.sltsl = 1'b0;
      bus.rd    = 1'b0;
      tick(3);
      check("wait_before_latency", bus.wait_n, 1'b1);
      tick(1);
      check("wait_at_latency", bus.wait_n, 1'b0);
      check("mem_req_issued", bus.mem_req, 1'b1);
      pop_check(bus.mem_addr);
      tick(ack_after - 1);
      check("wait_held", bus.wait_n, 1'b0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = d;
      tick(1);
      bus.mem_ack = 1'b0;
      check("oe_after_ack", bus.data_oe, 1'b1);
      check("wait_after_ack", bus.wait_n, 1'b1);
      check("req_after_ack", bus.mem_req, 1'b0);
      pop_check(bus.data_out);
      release_bus();
      tick(4);
      check("oe_after_rd_rise", bus.data_oe, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int low_cycles;

      bus.addr     = '0;
      bus.data_in  = '0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      do_reset();

      check("rst_wait", bus.wait_n, 1'b1);
      check("rst_busdir", bus.busdir, 1'b1);
      check("rst_oe", bus.data_oe, 1'b0);
      check("rst_data_out", bus.data_out, 8'hFF);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 20'h0);
      check("rst_ctrl", bus.ctrl, 8'h00);

      // Test 1: bank1 <= 0x25, read 0x6123 acked after 10 cycles.
      mem_write(16'h6800, 8'h25);
      mem_read(16'h6123, 20'h4A123, 10, 8'hA5);

      // Test 2: reset clears banks; out-of-window read is ignored.
      do_reset();
      mem_read(16'h4000, 20'h00000, 3, 8'h11);
      bus.addr  = 16'hC000;
      bus.mreq  = 1'b0;
      bus.sltsl = 1'b0;
      bus.rd    = 1'b0;
      tick(8);
      check("c000_wait", bus.wait_n, 1'b1);
      check("c000_req", bus.mem_req, 1'b0);
      check("c000_oe", bus.data_oe, 1'b0);
      release_bus();
      tick(4);

      // Test 3: I/O write then read of the control register.
      io_write(8'h5E, 8'h3C);
      check("ctrl_written", bus.ctrl, 8'h3C);
      push("io_data", 32'h3C);
      bus.addr = 16'h005E;
      bus.iorq = 1'b0;
      bus.rd   = 1'b0;
      tick(4);
      check("io_oe", bus.data_oe, 1'b1);
      check("io_busdir", bus.busdir, 1'b0);
      check("io_wait", bus.wait_n, 1'b1);
      pop_check(bus.data_out);
      release_bus();
      tick(4);
      check("io_oe_off", bus.data_oe, 1'b0);
      check("io_busdir_off", bus.busdir, 1'b1);

      // Test 4: bank2 <= 0x7F, read 0x8001 that is never acked in time.
      mem_write(16'h7000, 8'h7F);
      push("to_addr", 32'hFE001);
      push("to_data", 32'hFF);
      bus.addr  = 16'h8001;
      bus.mreq  = 1'b0;
      bus.sltsl = 1'b0;
      bus.rd    = 1'b0;
      tick(4);
      pop_check(bus.mem_addr);
      low_cycles = 0;
      for (int i = 0; i < 400 && bus.wait_n === 1'b0; i++) begin
         low_cycles++;
         tick(1);
      end
      check("timeout_low_cycles", low_cycles, 256);
      check("timeout_oe", bus.data_oe, 1'b1);
      pop_check(bus.data_out);
      check("timeout_req_held", bus.mem_req, 1'b1);
      release_bus();
      tick(5);
      check("drain_req_held", bus.mem_req, 1'b1);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 8'h5A;
      tick(1);
      bus.mem_ack = 1'b0;
      check("late_ack_req", bus.mem_req, 1'b0);
      check("late_ack_discarded", bus.data_out, 8'hFF);
      tick(2);
      check("drain_oe_off", bus.data_oe, 1'b0);

      // Test 5: interrupt acknowledge and RD+WR together change nothing.
      bus.addr    = 16'h005E;
      bus.data_in = 8'h99;
      bus.iorq    = 1'b0;
      bus.m1      = 1'b0;
      bus.rd      = 1'b0;
      tick(8);
      check("inta_rd_oe", bus.data_oe, 1'b0);
      check("inta_rd_busdir", bus.busdir, 1'b1);
      release_bus();
      tick(4);
      bus.iorq = 1'b0;
      bus.m1   = 1'b0;
      bus.wr   = 1'b0;
      tick(8);
      check("inta_wr_ctrl", bus.ctrl, 8'h3C);
      release_bus();
      tick(4);
      bus.addr    = 16'h6000;
      bus.data_in = 8'h44;
      bus.mreq    = 1'b0;
      bus.sltsl   = 1'b0;
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      tick(8);
      check("rdwr_wait", bus.wait_n, 1'b1);
      check("rdwr_req", bus.mem_req, 1'b0);
      check("rdwr_oe", bus.data_oe, 1'b0);
      release_bus();
      tick(4);
      mem_read(16'h4000, 20'h00000, 2, 8'h77);

      // Test 6: reset during an outstanding flash request.
      push("abort_addr", 32'hFE010);
      bus.addr  = 16'h8010;
      bus.mreq  = 1'b0;
      bus.sltsl = 1'b0;
      bus.rd    = 1'b0;
      tick(4);
      pop_check(bus.mem_addr);
      tick(3);
      reset = 1'b1;
      release_bus();
      tick(1);
      check("abort_wait", bus.wait_n, 1'b1);
      check("abort_req", bus.mem_req, 1'b0);
      check("abort_mem_addr", bus.mem_addr, 20'h0);
      check("abort_ctrl", bus.ctrl, 8'h00);
      tick(2);
      reset = 1'b0;
      tick(1);
      mem_read(16'h8010, 20'h00010, 4, 8'hC3);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
